// File: rtl/sega_joy_reader.sv
// sega_joy_reader
// Polls two DB9 joystick ports through one shared select line and decodes
// each as a Master System/Atari 2-button pad, a Mega Drive 3-button pad or a
// Mega Drive 6-button pad. Button words are active low, MXYZ SACB RLDU order.
//
// Ports:
//   clk_i       system clock
//   res_n_i     asynchronous active-low reset (released synchronously inside)
//   joy1_i      port 1 raw pins {p9,p6,right,left,down,up}, active low, async
//   joy2_i      port 2 raw pins, same order
//   joyX_p7_o   shared select line to both ports (registered)
//   joy1_o      port 1 buttons {M,X,Y,Z,S,A,C,B,R,L,D,U}, 0 = pressed
//   joy2_o      port 2 buttons, same format
//   joy1_six_o  port 1 identified as 6-button pad
//   joy2_six_o  port 2 identified as 6-button pad
//   upd_o       one-cycle strobe in the cycle joy*_o / *_six_o are refreshed
module sega_joy_reader #(
  parameter int CLK_DIV = 1536,
  parameter int STEP_W  = 8
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        joyX_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        joy1_six_o,
  output logic        joy2_six_o,
  output logic        upd_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [STEP_W-1:0] ST_LO0    = STEP_W'(0);
  localparam logic [STEP_W-1:0] ST_HI1    = STEP_W'(1);
  localparam logic [STEP_W-1:0] ST_SMP_HI = STEP_W'(2);
  localparam logic [STEP_W-1:0] ST_SMP_LO = STEP_W'(3);
  localparam logic [STEP_W-1:0] ST_LO3    = STEP_W'(4);
  localparam logic [STEP_W-1:0] ST_DET6   = STEP_W'(5);
  localparam logic [STEP_W-1:0] ST_XYZ    = STEP_W'(6);
  localparam logic [STEP_W-1:0] ST_COMMIT = STEP_W'(7);

  // Per-port shadow update for one tick; returns {six_tmp, shadow}.
  // Pin order is {p9,p6,R,L,D,U}, so pins[3:2] = {R,L} and pins[5:4] = {p9,p6}.
  function automatic logic [12:0] port_next(input logic [STEP_W-1:0] step,
                                            input logic [5:0]        pins,
                                            input logic [11:0]       sh,
                                            input logic              six);
    logic [11:0] sh_n;
    logic        six_n;
    sh_n  = sh;
    six_n = six;
    case (step)
      ST_SMP_HI: begin
        sh_n  = {6'b111111, pins};
        six_n = 1'b0;
      end
      ST_SMP_LO: begin
        // Left+right both low with select low marks a Mega Drive pad.
        if (pins[3:2] == 2'b00) begin
          sh_n[7:6] = pins[5:4];
        end else begin
          sh_n[7:4] = {2'b11, pins[5:4]};
        end
      end
      ST_DET6: begin
        // Only a 6-button pad drives all four directions low on the third low.
        if (pins[3:0] == 4'b0000) begin
          six_n = 1'b1;
        end else begin
          six_n = six;
        end
      end
      ST_XYZ: begin
        if (six) begin
          sh_n[11:8] = pins[3:0];
        end else begin
          sh_n[11:8] = 4'hF;
        end
      end
      default: begin
        sh_n  = sh;
        six_n = six;
      end
    endcase
    return {six_n, sh_n};
  endfunction

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;
  logic [5:0]        j1_meta_r, j1_sync_r, j2_meta_r, j2_sync_r;
  logic [DIV_W-1:0]  div_r, div_nx_s;
  logic [STEP_W-1:0] step_r, step_nx_s;
  logic              p7_r, p7_nx_s;
  logic [11:0]       sh1_r, sh1_nx_s, sh2_r, sh2_nx_s;
  logic              six_tmp1_r, six_tmp1_nx_s, six_tmp2_r, six_tmp2_nx_s;
  logic [11:0]       joy1_r, joy1_nx_s, joy2_r, joy2_nx_s;
  logic              six1_r, six1_nx_s, six2_r, six2_nx_s;
  logic              upd_r, upd_nx_s;
  logic              tick_s;

  // Reset synchroniser: asynchronous assertion, release aligned to clk_i.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Two-flop synchronisers for the asynchronous pad pins.
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      j1_meta_r <= 6'h3F;
      j1_sync_r <= 6'h3F;
      j2_meta_r <= 6'h3F;
      j2_sync_r <= 6'h3F;
    end else begin
      j1_meta_r <= joy1_i;
      j1_sync_r <= j1_meta_r;
      j2_meta_r <= joy2_i;
      j2_sync_r <= j2_meta_r;
    end
  end

  // Sequencer next-state: divider, step counter, select line, shadows, commit.
  always_comb begin
    tick_s        = (div_r == DIV_LAST);
    div_nx_s      = div_r + DIV_W'(1);
    step_nx_s     = step_r;
    p7_nx_s       = p7_r;
    sh1_nx_s      = sh1_r;
    sh2_nx_s      = sh2_r;
    six_tmp1_nx_s = six_tmp1_r;
    six_tmp2_nx_s = six_tmp2_r;
    joy1_nx_s     = joy1_r;
    joy2_nx_s     = joy2_r;
    six1_nx_s     = six1_r;
    six2_nx_s     = six2_r;
    upd_nx_s      = 1'b0;
    if (tick_s) begin
      div_nx_s  = '0;
      step_nx_s = step_r + STEP_W'(1);
      {six_tmp1_nx_s, sh1_nx_s} = port_next(step_r, j1_sync_r, sh1_r, six_tmp1_r);
      {six_tmp2_nx_s, sh2_nx_s} = port_next(step_r, j2_sync_r, sh2_r, six_tmp2_r);
      case (step_r)
        ST_LO0, ST_SMP_HI, ST_LO3, ST_XYZ: p7_nx_s = 1'b0;
        ST_HI1, ST_SMP_LO, ST_DET6:        p7_nx_s = 1'b1;
        ST_COMMIT: begin
          p7_nx_s   = 1'b1;
          joy1_nx_s = sh1_r;
          joy2_nx_s = sh2_r;
          six1_nx_s = six_tmp1_r;
          six2_nx_s = six_tmp2_r;
          upd_nx_s  = 1'b1;
        end
        default: p7_nx_s = 1'b1;
      endcase
    end else begin
      upd_nx_s = 1'b0;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      div_r      <= '0;
      step_r     <= '0;
      p7_r       <= 1'b1;
      sh1_r      <= 12'hFFF;
      sh2_r      <= 12'hFFF;
      six_tmp1_r <= 1'b0;
      six_tmp2_r <= 1'b0;
      joy1_r     <= 12'hFFF;
      joy2_r     <= 12'hFFF;
      six1_r     <= 1'b0;
      six2_r     <= 1'b0;
      upd_r      <= 1'b0;
    end else begin
      div_r      <= div_nx_s;
      step_r     <= step_nx_s;
      p7_r       <= p7_nx_s;
      sh1_r      <= sh1_nx_s;
      sh2_r      <= sh2_nx_s;
      six_tmp1_r <= six_tmp1_nx_s;
      six_tmp2_r <= six_tmp2_nx_s;
      joy1_r     <= joy1_nx_s;
      joy2_r     <= joy2_nx_s;
      six1_r     <= six1_nx_s;
      six2_r     <= six2_nx_s;
      upd_r      <= upd_nx_s;
    end
  end

  assign joyX_p7_o  = p7_r;
  assign joy1_o     = joy1_r;
  assign joy2_o     = joy2_r;
  assign joy1_six_o = six1_r;
  assign joy2_six_o = six2_r;
  assign upd_o      = upd_r;

endmodule

// File: tb/tb_sega_joy_reader.sv
// Directed bench for sega_joy_reader with CLK_DIV = 8 (2048 clocks per poll).
// Pads are modelled behaviourally from the select line the DUT drives.
module tb_sega_joy_reader;

  logic        clk_i   = 1'b0;
  logic        res_n_i = 1'b0;
  logic [5:0]  joy1_i, joy2_i;
  logic        joyX_p7_o;
  logic [11:0] joy1_o, joy2_o;
  logic        joy1_six_o, joy2_six_o, upd_o;

  // Pad kind: 0 none, 1 two-button, 2 three-button, 3 six-button.
  int          kind1 = 0, kind2 = 0;
  // Pressed buttons, active low, {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  logic [11:0] btn1 = 12'hFFF, btn2 = 12'hFFF;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic        p7_q     = 1'b1;
  int          high_cnt = 0;
  int          low_cnt  = 0;

  always #5 clk_i = ~clk_i;

  sega_joy_reader #(.CLK_DIV(8), .STEP_W(8)) dut (
    .clk_i      (clk_i),
    .res_n_i    (res_n_i),
    .joy1_i     (joy1_i),
    .joy2_i     (joy2_i),
    .joyX_p7_o  (joyX_p7_o),
    .joy1_o     (joy1_o),
    .joy2_o     (joy2_o),
    .joy1_six_o (joy1_six_o),
    .joy2_six_o (joy2_six_o),
    .upd_o      (upd_o)
  );

  // Pins seen on the connector for a pad of the given kind.
  function automatic logic [5:0] pad_pins(input int kind, input logic sel,
                                          input int lows, input logic [11:0] b);
    logic [5:0] p;
    case (kind)
      1: p = b[5:0];
      2, 3: begin
        if (kind == 3 && lows == 3 && sel)
          p = {b[5], b[4], b[11], b[10], b[9], b[8]};
        else if (kind == 3 && lows == 3)
          p = {b[7], b[6], 4'b0000};
        else if (kind == 3 && lows == 4 && !sel)
          p = {b[7], b[6], 4'b1111};
        else if (sel)
          p = b[5:0];
        else
          p = {b[7], b[6], 2'b00, b[1], b[0]};
      end
      default: p = 6'h3F;
    endcase
    return p;
  endfunction

  assign joy1_i = pad_pins(kind1, joyX_p7_o, low_cnt, btn1);
  assign joy2_i = pad_pins(kind2, joyX_p7_o, low_cnt, btn2);

  // 6-button pad counter: counts select lows, clears after a long high.
  always @(posedge clk_i) begin
    p7_q <= joyX_p7_o;
    if (joyX_p7_o) high_cnt <= high_cnt + 1;
    else high_cnt <= 0;
    if (p7_q && !joyX_p7_o) low_cnt <= low_cnt + 1;
    else if (high_cnt > 32) low_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_upd(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (upd_o !== 1'b1 && cyc < bound);
    chk("upd_seen", {31'd0, upd_o}, 32'd1);
  endtask

  task automatic wait_p7_fall(input int bound);
    logic prev;
    int   cyc;
    cyc  = 0;
    prev = joyX_p7_o;
    @(negedge clk_i);
    while (!(prev === 1'b1 && joyX_p7_o === 1'b0) && cyc < bound) begin
      prev = joyX_p7_o;
      @(negedge clk_i);
      cyc++;
    end
    chk("p7_fall_seen", {31'd0, joyX_p7_o}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [11:0] s1, s2;
    logic        x1, x2;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_p7",   {31'd0, joyX_p7_o},  32'd1);
    chk("rst_joy1", {20'd0, joy1_o},     32'hFFF);
    chk("rst_joy2", {20'd0, joy2_o},     32'hFFF);
    chk("rst_six1", {31'd0, joy1_six_o}, 32'd0);
    chk("rst_six2", {31'd0, joy2_six_o}, 32'd0);
    chk("rst_upd",  {31'd0, upd_o},      32'd0);
    res_n_i = 1'b1;

    // Select pattern: 0,1,0,1,0,1,0 on steps 0-6, then 1 through step 255
    wait_p7_fall(100);
    repeat (4) @(negedge clk_i);
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("p7_step%0d", k), {31'd0, joyX_p7_o},
          (k < 7 && (k % 2) == 0) ? 32'd0 : 32'd1);
      repeat (8) @(negedge clk_i);
    end

    // No pad: all released, poll period 2048 clocks
    wait_upd(2100, c);
    chk("nopad_joy1", {20'd0, joy1_o},     32'hFFF);
    chk("nopad_joy2", {20'd0, joy2_o},     32'hFFF);
    chk("nopad_six1", {31'd0, joy1_six_o}, 32'd0);
    chk("nopad_six2", {31'd0, joy2_six_o}, 32'd0);
    wait_upd(2100, c);
    chk("upd_period", c, 32'd2048);

    // 3-button pad on port 1: A + Start + Up
    kind1 = 2; btn1 = 12'hF3E;
    wait_upd(2100, c);
    chk("pad3_joy1", {20'd0, joy1_o},     32'hF3E);
    chk("pad3_six1", {31'd0, joy1_six_o}, 32'd0);
    chk("pad3_joy2", {20'd0, joy2_o},     32'hFFF);

    // 6-button pad on port 2: X + Mode + B -> M=0,X=0,Y=1,Z=1
    kind2 = 3; btn2 = 12'h3EF;
    wait_upd(2100, c);
    chk("pad6a_joy2", {20'd0, joy2_o},     32'h3EF);
    chk("pad6a_six2", {31'd0, joy2_six_o}, 32'd1);
    chk("pad6a_joy1", {20'd0, joy1_o},     32'hF3E);

    // 6-button pad on port 2: Mode + Y + B -> M=0,X=1,Y=0,Z=1
    btn2 = 12'h5EF;
    wait_upd(2100, c);
    chk("pad6b_joy2", {20'd0, joy2_o},     32'h5EF);
    chk("pad6b_six2", {31'd0, joy2_six_o}, 32'd1);

    // 2-button pad on port 1: p6 (B) + Right
    kind1 = 1; btn1 = 12'hFE7;
    wait_upd(2100, c);
    chk("pad2_joy1", {20'd0, joy1_o},     32'hFE7);
    chk("pad2_six1", {31'd0, joy1_six_o}, 32'd0);

    // Pin activity during idle must not move the outputs
    s1 = joy1_o; s2 = joy2_o; x1 = joy1_six_o; x2 = joy2_six_o;
    for (int i = 0; i < 1400; i++) begin
      kind1 = $urandom_range(0, 3); kind2 = $urandom_range(0, 3);
      btn1 = 12'($urandom); btn2 = 12'($urandom);
      @(negedge clk_i);
      chk("hold_joy1", {20'd0, joy1_o}, {20'd0, s1});
      chk("hold_joy2", {20'd0, joy2_o}, {20'd0, s2});
      chk("hold_six",  {30'd0, joy1_six_o, joy2_six_o}, {30'd0, x1, x2});
      chk("hold_upd",  {31'd0, upd_o}, 32'd0);
    end
    kind1 = 0; kind2 = 0; btn1 = 12'hFFF; btn2 = 12'hFFF;
    wait_upd(2100, c);
    chk("clear_joy1", {20'd0, joy1_o}, 32'hFFF);
    chk("clear_joy2", {20'd0, joy2_o}, 32'hFFF);
    chk("clear_six",  {30'd0, joy1_six_o, joy2_six_o}, 32'd0);

    // Everything pressed on a 6-button pad on port 1
    kind1 = 3; btn1 = 12'h000;
    wait_upd(2100, c);
    chk("all_joy1", {20'd0, joy1_o},     32'h000);
    chk("all_six1", {31'd0, joy1_six_o}, 32'd1);

    // Reset in the middle of step 4
    wait_p7_fall(2100);
    repeat (28) @(negedge clk_i);
    res_n_i = 1'b0;
    #1;
    chk("midrst_joy1", {20'd0, joy1_o},     32'hFFF);
    chk("midrst_p7",   {31'd0, joyX_p7_o},  32'd1);
    chk("midrst_six1", {31'd0, joy1_six_o}, 32'd0);
    chk("midrst_upd",  {31'd0, upd_o},      32'd0);
    repeat (40) @(negedge clk_i);
    res_n_i = 1'b1;
    wait_upd(200, c);
    chk("midrst_upd_latency", {31'd0, (c >= 64 && c <= 70)}, 32'd1);
    chk("midrst_joy1_after",  {20'd0, joy1_o},     32'h000);
    chk("midrst_six1_after",  {31'd0, joy1_six_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
